// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_if
//  Description : Control-bus bundle between the control sequencer and the
//                16-bit datapath / instruction memory.
//                master modport : the sequencer (drives control outputs)
//                slave  modport : datapath / memory side (drives status)
//  Signals     : run, imem_ack, opcode[2:0], branch_eq         (to sequencer)
//                imem_req, ir_load, alu_src_imm, reg_write,
//                pc_inc, pc_load, halted, fault, state[2:0],
//                retired_count[COUNT_W-1:0]                    (from sequencer)
//  Revision    : 1.0  initial release
// ============================================================================
interface control_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic               run;
    logic               imem_ack;
    logic [2:0]         opcode;
    logic               branch_eq;

    logic               imem_req;
    logic               ir_load;
    logic               alu_src_imm;
    logic               reg_write;
    logic               pc_inc;
    logic               pc_load;
    logic               halted;
    logic               fault;
    logic [2:0]         state;
    logic [COUNT_W-1:0] retired_count;

    modport master (
        input  run, imem_ack, opcode, branch_eq,
        output imem_req, ir_load, alu_src_imm, reg_write,
               pc_inc, pc_load, halted, fault, state, retired_count
    );

    modport slave (
        output run, imem_ack, opcode, branch_eq,
        input  imem_req, ir_load, alu_src_imm, reg_write,
               pc_inc, pc_load, halted, fault, state, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Multi-cycle control FSM for the 16-bit datapath. Sequences
//                FETCH (req/ack), DECODE, EXECUTE, WRITEBACK; resolves BEQ,
//                counts retired instructions, halts on HALT and enters a
//                sticky FAULT state on instruction-memory timeout.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous active-high reset
//                bus    - control_sequencer_if.master (see interface file)
//  Parameters  : TIMEOUT_CYCLES - FETCH cycles without ack before FAULT
//                                 (2..256)
//                COUNT_W        - width of retired_count
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int COUNT_W        = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    control_sequencer_if.master   bus
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int c_WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_OP_BEQ  = 3'b100;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5,
        S_FAULT     = 3'd6,
        S_UNUSED    = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [2:0]           r_op;
    logic [c_WAIT_W-1:0]  r_wait;
    logic [COUNT_W-1:0]   r_retired;

    logic                 w_imem_req;
    logic                 w_ir_load;
    logic                 w_alu_src_imm;
    logic                 w_reg_write;
    logic                 w_pc_inc;
    logic                 w_pc_load;
    logic                 w_halted;
    logic                 w_fault;
    logic                 w_retire;
    logic                 w_op_alu;
    logic                 w_op_imm;
    logic                 w_timeout;

    // Opcodes 000-011 are ALU ops; 010/011 take the immediate operand.
    assign w_op_alu  = (r_op[2] == 1'b0);
    assign w_op_imm  = (r_op[2:1] == 2'b01);
    assign w_timeout = (r_wait == c_WAIT_LAST);

    // ------------------------------------------------------------------
    // State, opcode latch, fetch-wait counter and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'b000;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_DECODE) begin
                r_op <= bus.opcode;
            end

            // The counter only runs while waiting in FETCH; an ack or a
            // timeout ends the wait, and any other state keeps it clear so
            // each fetch starts a fresh budget.
            if ((r_state == S_FETCH) && !bus.imem_ack && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end

            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_imem_req    = 1'b0;
        w_ir_load     = 1'b0;
        w_alu_src_imm = 1'b0;
        w_reg_write   = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_load     = 1'b0;
        w_halted      = 1'b0;
        w_fault       = 1'b0;
        w_retire      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_next_state = S_FETCH;
                end
            end

            S_FETCH: begin
                w_imem_req = 1'b1;
                // An ack in the final allowed cycle still wins over FAULT.
                if (bus.imem_ack) begin
                    w_ir_load    = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end
            end

            S_DECODE: begin
                if (bus.opcode == c_OP_HALT) begin
                    w_next_state = S_HALTED;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                w_alu_src_imm = w_op_imm;
                if (w_op_alu) begin
                    w_next_state = S_WRITEBACK;
                end else begin
                    // BEQ or NOP: the instruction completes here.
                    if (r_op == c_OP_BEQ) begin
                        w_pc_load = bus.branch_eq;
                        w_pc_inc  = !bus.branch_eq;
                    end else begin
                        w_pc_inc  = 1'b1;
                    end
                    w_retire     = 1'b1;
                    w_next_state = bus.run ? S_FETCH : S_IDLE;
                end
            end

            S_WRITEBACK: begin
                // Operand select is held so the ALU result stays stable
                // through the register-file write.
                w_alu_src_imm = w_op_imm;
                w_reg_write   = 1'b1;
                w_pc_inc      = 1'b1;
                w_retire      = 1'b1;
                w_next_state  = bus.run ? S_FETCH : S_IDLE;
            end

            S_HALTED: begin
                w_halted = 1'b1;
            end

            S_FAULT: begin
                w_fault = 1'b1;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req      = w_imem_req;
    assign bus.ir_load       = w_ir_load;
    assign bus.alu_src_imm   = w_alu_src_imm;
    assign bus.reg_write     = w_reg_write;
    assign bus.pc_inc        = w_pc_inc;
    assign bus.pc_load       = w_pc_load;
    assign bus.halted        = w_halted;
    assign bus.fault         = w_fault;
    assign bus.state         = r_state;
    assign bus.retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Directed self-checking bench for control_sequencer.
//                Inputs change at the falling edge; outputs are sampled 1 ns
//                later. Output vector order:
//                {imem_req, ir_load, alu_src_imm, reg_write,
//                 pc_inc, pc_load, halted, fault}
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    control_sequencer_if #(.COUNT_W(16)) bus ();

    control_sequencer #(
        .TIMEOUT_CYCLES (16),
        .COUNT_W        (16)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    wire [7:0] w_outs = {bus.imem_req, bus.ir_load, bus.alu_src_imm, bus.reg_write,
                         bus.pc_inc, bus.pc_load, bus.halted, bus.fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then return to the sampling point after the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.opcode    = 3'b000;
        bus.branch_eq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++;
        if ({bus.state, w_outs} !== {3'd0, 8'h00} || bus.retired_count !== 16'd0)
            $display("FAIL reset_state: state=%0d outs=%b cnt=%0d, want 0 00000000 0",
                     bus.state, w_outs, bus.retired_count);
        else n_pass++;
    endtask

    // ADD with immediate ack: 1,2,3,4 then back to FETCH with count 1.
    task automatic test_add();
        logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        logic [7:0] exp_o  [5] = '{8'b1100_0000, 8'b0000_0000, 8'b0000_0000,
                                  8'b0001_1000, 8'b1100_0000};
        do_reset();
        bus.run = 1'b1; bus.imem_ack = 1'b1; bus.opcode = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            n_total++;
            if ({bus.state, w_outs} !== {exp_st[i], exp_o[i]})
                $display("FAIL add_seq[%0d]: state=%0d outs=%b, want %0d %b",
                         i, bus.state, w_outs, exp_st[i], exp_o[i]);
            else n_pass++;
        end
        n_total++;
        if (bus.retired_count !== 16'd1)
            $display("FAIL add_retired: got %0d want 1", bus.retired_count);
        else n_pass++;
    endtask

    // ADDI with two wait cycles, then run=0 at the boundary drops to IDLE.
    task automatic test_addi_wait();
        logic [2:0] exp_st [6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [7:0] exp_o  [6] = '{8'b1000_0000, 8'b1000_0000, 8'b1100_0000,
                                  8'b0000_0000, 8'b0010_0000, 8'b0011_1000};
        do_reset();
        bus.run = 1'b1; bus.imem_ack = 1'b0; bus.opcode = 3'b010;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.imem_ack = (i == 2);
            if (i == 5) bus.run = 1'b0;
            #1;
            n_total++;
            if ({bus.state, w_outs} !== {exp_st[i], exp_o[i]})
                $display("FAIL addi_seq[%0d]: state=%0d outs=%b, want %0d %b",
                         i, bus.state, w_outs, exp_st[i], exp_o[i]);
            else n_pass++;
        end
        step(); #1;
        n_total++;
        if ({bus.state, w_outs} !== {3'd0, 8'h00} || bus.retired_count !== 16'd1)
            $display("FAIL boundary_idle: state=%0d outs=%b cnt=%0d, want 0 00000000 1",
                     bus.state, w_outs, bus.retired_count);
        else n_pass++;
    endtask

    // BEQ taken, BEQ not taken, then a NOP (3 cycles each).
    task automatic test_branch();
        logic       beq [3] = '{1'b1, 1'b0, 1'b0};
        logic [2:0] opc [3] = '{3'b100, 3'b100, 3'b101};
        logic [7:0] exp [3] = '{8'b0000_0100, 8'b0000_1000, 8'b0000_1000};
        do_reset();
        bus.run = 1'b1; bus.imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.opcode = opc[i]; bus.branch_eq = beq[i];
            step(); step(); step(); #1;
            n_total++;
            if ({bus.state, w_outs} !== {3'd3, exp[i]})
                $display("FAIL branch_exec[%0d]: state=%0d outs=%b, want 3 %b",
                         i, bus.state, w_outs, exp[i]);
            else n_pass++;
        end
        step(); #1;
        n_total++;
        if ({bus.state, bus.retired_count} !== {3'd1, 16'd3})
            $display("FAIL branch_retired: state=%0d cnt=%0d, want 1 3",
                     bus.state, bus.retired_count);
        else n_pass++;
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        bus.run = 1'b1; bus.imem_ack = 1'b1; bus.opcode = 3'b000;
        for (int i = 0; i < 4; i++) step();
        bus.opcode = 3'b111;
        step(); step(); step(); #1;
        n_total++;
        if ({bus.state, w_outs} !== {3'd5, 8'b0000_0010} || bus.retired_count !== 16'd1)
            $display("FAIL halt_enter: state=%0d outs=%b cnt=%0d, want 5 00000010 1",
                     bus.state, w_outs, bus.retired_count);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(); #1;
            if (bus.state !== 3'd5 || bus.retired_count !== 16'd1 || w_outs !== 8'b0000_0010)
                bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL halt_hold: %0d bad cycles, want 0", bad);
        else n_pass++;
        do_reset(); #1;
        n_total++;
        if ({bus.state, bus.retired_count} !== {3'd0, 16'd0})
            $display("FAIL halt_reset: state=%0d cnt=%0d, want 0 0",
                     bus.state, bus.retired_count);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        bus.run = 1'b1; bus.imem_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            step(); #1;
            if (bus.state !== 3'd1 || bus.fault !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL timeout_wait: %0d bad cycles, want 0", bad);
        else n_pass++;
        step(); #1;
        n_total++;
        if ({bus.state, w_outs} !== {3'd6, 8'b0000_0001})
            $display("FAIL timeout_fault: state=%0d outs=%b, want 6 00000001",
                     bus.state, w_outs);
        else n_pass++;
        bus.imem_ack = 1'b1;
        step(); step(); #1;
        n_total++;
        if ({bus.state, w_outs} !== {3'd6, 8'b0000_0001})
            $display("FAIL fault_sticky: state=%0d outs=%b, want 6 00000001",
                     bus.state, w_outs);
        else n_pass++;

        // Ack arriving in the 16th FETCH cycle wins over the timeout.
        do_reset();
        bus.run = 1'b1; bus.imem_ack = 1'b0;
        for (int i = 0; i < 15; i++) step();
        step();
        bus.imem_ack = 1'b1;
        #1;
        n_total++;
        if ({bus.state, w_outs} !== {3'd1, 8'b1100_0000})
            $display("FAIL late_ack_fetch: state=%0d outs=%b, want 1 11000000",
                     bus.state, w_outs);
        else n_pass++;
        step(); #1;
        n_total++;
        if ({bus.state, bus.fault} !== {3'd2, 1'b0})
            $display("FAIL late_ack_decode: state=%0d fault=%b, want 2 0",
                     bus.state, bus.fault);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.run = 1'b1; bus.imem_ack = 1'b1; bus.opcode = 3'b000;
        for (int i = 0; i < 8; i++) step();
        #1;
        n_total++;
        if ({bus.state, w_outs, bus.retired_count} !== {3'd4, 8'b0001_1000, 16'd1})
            $display("FAIL pre_reset_wb: state=%0d outs=%b cnt=%0d, want 4 00011000 1",
                     bus.state, w_outs, bus.retired_count);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({bus.state, w_outs, bus.retired_count} !== {3'd0, 8'h00, 16'd0})
            $display("FAIL async_reset: state=%0d outs=%b cnt=%0d, want 0 00000000 0",
                     bus.state, w_outs, bus.retired_count);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({bus.state, bus.retired_count} !== {3'd0, 16'd0})
            $display("FAIL reset_held: state=%0d cnt=%0d, want 0 0",
                     bus.state, bus.retired_count);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.opcode    = 3'b000;
        bus.branch_eq = 1'b0;
        test_reset();
        test_add();
        test_addi_wait();
        test_branch();
        test_halt();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control FSM that sequences the 16-bit processor datapath: instruction fetch with a req/ack handshake, decode, execute, writeback and branch resolution.
- Drives the PC, instruction-register load, register-file write enable and ALU operand-B select.
- Counts retired instructions.
- Detects instruction-memory timeouts and enters a sticky FAULT state.

Parameters:
- TIMEOUT_CYCLES, 16: maximum FETCH cycles without imem_ack before FAULT (legal range 2..256).
- COUNT_W, 16: width of retired_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  permit fetching new instructions.
- imem_ack  input  1  instruction memory has valid data this cycle.
- opcode  input  3  instruction[15:13]; valid from the DECODE state onward.
- branch_eq  input  1  BEQ compare result (rs1 == rs2); sampled in EXECUTE.
- imem_req  output  1  fetch request.
- ir_load  output  1  load instruction register (one-cycle pulse).
- alu_src_imm  output  1  select the zero-extended 4-bit immediate as ALU operand B.
- reg_write  output  1  register-file write enable.
- pc_inc  output  1  PC <= PC+1 at the next edge.
- pc_load  output  1  PC <= branch target at the next edge.
- halted  output  1  HALTED state.
- fault  output  1  FAULT state.
- state  output  3  current state encoding.
- retired_count  output  COUNT_W  number of instructions retired.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5, FAULT=6; 7 is unused and recovers to IDLE.
- Reset (asynchronous, any state, mid-instruction included): state=IDLE, op_q=0, wait counter=0, retired_count=0. All outputs are 0 while reset is high and in IDLE. No partial writeback completes.
- All outputs are combinational decodes of state, op_q, imem_ack and branch_eq. At most one of pc_inc/pc_load is high in any cycle.
- Opcodes:
  - 000 ADD, 001 SUB: ALU, register operand.
  - 010 ADDI, 011 SUBI: ALU, immediate operand.
  - 100 BEQ.
  - 101, 110: NOP.
  - 111: HALT.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1.
  - If imem_ack=1: ir_load=1 this cycle, wait counter cleared, go to DECODE.
  - Otherwise the wait counter increments.
  - If the counter equals TIMEOUT_CYCLES-1 and imem_ack=0, go to FAULT.
  - imem_ack in the timeout cycle takes priority over FAULT.
- DECODE: op_q <= opcode. If opcode=111, go to HALTED; otherwise go to EXECUTE.
- EXECUTE:
  - alu_src_imm=1 for op_q 010/011, else 0.
  - ALU ops (000-011): go to WRITEBACK.
  - BEQ: pc_load=branch_eq and pc_inc=!branch_eq; retire; go to the boundary.
  - NOP: pc_inc=1; retire; go to the boundary.
- WRITEBACK: reg_write=1; alu_src_imm held from EXECUTE; pc_inc=1; retire; go to the boundary.
- Boundary: next state is FETCH if run=1, otherwise IDLE. run is sampled only in IDLE and at boundaries; deasserting it mid-instruction never aborts that instruction.
- Retire: retired_count increments by 1, wrapping from all-ones to 0.
- Per-instruction latency, with zero fetch wait (FETCH cycle counted):
  - ALU ops: 4 cycles.
  - BEQ and NOP: 3 cycles.
- HALTED: halted=1, PC frozen, retired_count frozen (HALT is not counted). Exit only via reset.
- FAULT: fault=1, all other outputs 0. Exit only via reset.
- imem_ack outside FETCH is ignored.

Test Plan:
- Reset, run=1, imem_ack=1 every cycle, opcode=000: state sequence 1,2,3,4,1. reg_write=1 only in state 4. retired_count=1 after 4 cycles; alu_src_imm=0 throughout.
- opcode=010, imem_ack delayed 2 cycles: imem_req high 3 cycles; ir_load pulses once, in the 3rd; alu_src_imm=1 in EXECUTE and WRITEBACK.
- BEQ with branch_eq=1, then BEQ with branch_eq=0: pc_load=1 in the first EXECUTE, pc_inc=1 in the second. reg_write is never asserted; retired_count=2.
- opcode=111 after one ADD: halted=1 and state=5. retired_count stays 1 for 20 cycles with run=1; reset returns to state 0 with count 0.
- imem_ack held 0, TIMEOUT_CYCLES=16: fault=1 after 16 FETCH cycles. With imem_ack=1 in the 16th cycle instead, DECODE is entered with no fault.
- Reset asserted asynchronously mid-WRITEBACK: state=0 and all outputs 0 immediately; retired_count=0. run=0 at a boundary leaves the FSM in IDLE with imem_req=0.
